// File: rtl/id_pipe_stage.sv
// id_pipe_stage: RV64I/RV32I decode stage feeding a 2-entry skid buffer.
// Define ID_ILLEGAL_EN to flag undecodable encodings on out_illegal.
module id_pipe_stage #(
  parameter int XLEN  = 64,
  parameter int ALU_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             rs1_r_ena,
  output logic             rs2_r_ena,
  output logic [4:0]       rs1_r_addr,
  output logic [4:0]       rs2_r_addr,
  input  logic [XLEN-1:0]  r_data1,
  input  logic [XLEN-1:0]  r_data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [XLEN-1:0]  out_jmp,
  output logic [ALU_W-1:0] out_alu,
  output logic [7:0]       out_bj,
  output logic [6:0]       out_load,
  output logic [3:0]       out_save,
  output logic             out_rd_wena,
  output logic [4:0]       out_rd_addr,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic             out_is_word,
  output logic             out_illegal
);
  localparam bit RV64 = XLEN == 64;
  localparam logic [9:0] A_ADD = 10'h001, A_SUB = 10'h002, A_SLT = 10'h004, A_SLTU = 10'h008,
    A_XOR = 10'h010, A_OR = 10'h020, A_AND = 10'h040, A_SLL = 10'h080, A_SRL = 10'h100, A_SRA = 10'h200;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [XLEN-1:0]  jmp;
    logic [ALU_W-1:0] alu;
    logic [7:0]       bj;
    logic [6:0]       load;
    logic [3:0]       save;
    logic             rd_wena;
    logic [4:0]       rd_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic             is_word;
    logic             illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st;
  logic is_opi, is_op, is_opiw, is_opw, is_fence, is_sys;
  logic sh_ok, f7_ok, legal, alt, rd_en;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, jalr_sum;
  logic [9:0] alu_f3, alu10;
  bundle_t dec, m_q, s_q;
  state_t state_q;
  logic in_ready_q, out_valid_q;
  logic push, pop;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6f;
  assign is_jalr  = opc == 7'h67;
  assign is_br    = opc == 7'h63;
  assign is_ld    = opc == 7'h03;
  assign is_st    = opc == 7'h23;
  assign is_opi   = opc == 7'h13;
  assign is_op    = opc == 7'h33;
  assign is_opiw  = RV64 && opc == 7'h1b;
  assign is_opw   = RV64 && opc == 7'h3b;
  assign is_fence = opc == 7'h0f;
  assign is_sys   = opc == 7'h73;

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign jalr_sum = r_data1 + imm_i;

  // RV64 shift immediates carry a 6-bit shamt, so only inst[31:26] is funct
  assign sh_ok = RV64 ? (in_inst[31:26] == 6'h00 || (f3 == 3'd5 && in_inst[31:26] == 6'h10))
                      : (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
  assign f7_ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  assign legal = is_lui | is_auipc | is_jal
    | (is_jalr & f3 == 3'd0)
    | (is_br & f3[2:1] != 2'b01)
    | (is_ld & f3 != 3'd7 & (RV64 | (f3 != 3'd3 & f3 != 3'd6)))
    | (is_st & ~f3[2] & (RV64 | f3 != 3'd3))
    | (is_opi & ((f3 != 3'd1 & f3 != 3'd5) | sh_ok))
    | (is_op & f7_ok)
    | (is_opiw & (f3 == 3'd0 | ((f3 == 3'd1 | f3 == 3'd5) & f7_ok)))
    | (is_opw & (f3 == 3'd0 | f3 == 3'd1 | f3 == 3'd5) & f7_ok)
    | (is_fence & f3 == 3'd0)
    | (is_sys & (in_inst[31:7] == 25'h0 | in_inst[31:7] == 25'h2000));

  assign alt = in_inst[30] & (is_op | is_opw | f3 == 3'd5);
  assign alu_f3 = f3 == 3'd0 ? (alt ? A_SUB : A_ADD) : f3 == 3'd1 ? A_SLL : f3 == 3'd2 ? A_SLT :
                  f3 == 3'd3 ? A_SLTU : f3 == 3'd4 ? A_XOR : f3 == 3'd5 ? (alt ? A_SRA : A_SRL) :
                  f3 == 3'd6 ? A_OR : A_AND;
  assign alu10 = (is_op | is_opi | is_opiw | is_opw) ? alu_f3 :
                 (is_lui | is_auipc | is_ld | is_st) ? A_ADD : 10'h000;
  assign rd_en = legal & (is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op | is_opiw | is_opw);

  assign rs1_r_ena  = is_jalr | is_br | is_ld | is_st | is_opi | is_op | is_opiw | is_opw;
  assign rs2_r_ena  = is_br | is_st | is_op | is_opw;
  assign rs1_r_addr = rs1_r_ena ? in_inst[19:15] : 5'd0;
  assign rs2_r_addr = rs2_r_ena ? in_inst[24:20] : 5'd0;

  always_comb begin
    dec = '0;
    dec.pc = in_pc;
    dec.op1 = is_auipc ? in_pc : is_lui ? '0 : r_data1;
    dec.op2 = (is_op | is_opw | is_br) ? r_data2 : is_st ? imm_s : (is_lui | is_auipc) ? imm_u :
              is_jal ? imm_j : imm_i;
    dec.jmp = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : is_br ? imm_b : is_jal ? imm_j : '0;
    dec.alu = legal ? ALU_W'(alu10) : '0;
    dec.bj = ~legal ? 8'h00 : is_br ? {2'b00, f3 == 3'd7, f3 == 3'd6, f3 == 3'd5, f3 == 3'd4, f3 == 3'd1, f3 == 3'd0}
                                    : {is_jalr, is_jal, 6'b000000};
    dec.load = legal & is_ld ? {f3 == 3'd6, f3 == 3'd5, f3 == 3'd4, f3 == 3'd3, f3 == 3'd2, f3 == 3'd1, f3 == 3'd0} : 7'h00;
    dec.save = legal & is_st ? {f3 == 3'd3, f3 == 3'd2, f3 == 3'd1, f3 == 3'd0} : 4'h0;
    dec.rd_wena = rd_en;
    dec.rd_addr = rd_en ? in_inst[11:7] : 5'd0;
    dec.mem_rd = legal & is_ld;
    dec.mem_wr = legal & is_st;
    dec.is_word = legal & (is_opiw | is_opw);
`ifdef ID_ILLEGAL_EN
    dec.illegal = ~legal;
`else
    dec.illegal = 1'b0;
`endif
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_q         <= '0;
      s_q         <= '0;
    end else if (flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_q     <= ONE;
          m_q         <= dec;
          out_valid_q <= 1'b1;
        end
        ONE: if (push & ~pop) begin
          state_q    <= TWO;
          s_q        <= dec;
          in_ready_q <= 1'b0;
        end else if (push) begin
          m_q <= dec;
        end else if (pop) begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
        end
        TWO: if (pop) begin
          state_q    <= ONE;
          m_q        <= s_q;
          in_ready_q <= 1'b1;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = m_q.pc;
  assign out_op1     = m_q.op1;
  assign out_op2     = m_q.op2;
  assign out_jmp     = m_q.jmp;
  assign out_alu     = m_q.alu;
  assign out_bj      = m_q.bj;
  assign out_load    = m_q.load;
  assign out_save    = m_q.save;
  assign out_rd_wena = m_q.rd_wena;
  assign out_rd_addr = m_q.rd_addr;
  assign out_mem_rd  = m_q.mem_rd;
  assign out_mem_wr  = m_q.mem_wr;
  assign out_is_word = m_q.is_word;
  assign out_illegal = m_q.illegal;
endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: directed tests of id_pipe_stage at XLEN=64 plus an XLEN=32 instance.
module tb_id_pipe_stage;
  localparam logic [9:0] A_ADD = 10'h001, A_SUB = 10'h002;
`ifdef ID_ILLEGAL_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [31:0] in_inst = 32'h0;
  logic [63:0] in_pc = '0, r_data1 = '0, r_data2 = '0;
  logic rs1_r_ena, rs2_r_ena;
  logic [4:0] rs1_r_addr, rs2_r_addr, out_rd_addr;
  logic [63:0] out_pc, out_op1, out_op2, out_jmp;
  logic [9:0] out_alu;
  logic [7:0] out_bj;
  logic [6:0] out_load;
  logic [3:0] out_save;
  logic out_rd_wena, out_mem_rd, out_mem_wr, out_is_word, out_illegal;

  logic v32 = 1'b0, rdy32, ov32, r32_e1, r32_e2, wena32, mrd32, mwr32, word32, ill32;
  logic [31:0] inst32 = 32'h0, pc32 = 32'h0, d32 = 32'h0;
  logic [4:0] r32_a1, r32_a2, rd32;
  logic [31:0] opc32, op1_32, op2_32, jmp32;
  logic [9:0] alu32;
  logic [7:0] bj32;
  logic [6:0] ld32;
  logic [3:0] sv32;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  id_pipe_stage #(.XLEN(64), .ALU_W(10)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1_r_ena(rs1_r_ena), .rs2_r_ena(rs2_r_ena),
    .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr), .r_data1(r_data1), .r_data2(r_data2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op1(out_op1),
    .out_op2(out_op2), .out_jmp(out_jmp), .out_alu(out_alu), .out_bj(out_bj),
    .out_load(out_load), .out_save(out_save), .out_rd_wena(out_rd_wena),
    .out_rd_addr(out_rd_addr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_is_word(out_is_word), .out_illegal(out_illegal));

  id_pipe_stage #(.XLEN(32), .ALU_W(10)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v32), .in_ready(rdy32),
    .in_inst(inst32), .in_pc(pc32), .rs1_r_ena(r32_e1), .rs2_r_ena(r32_e2),
    .rs1_r_addr(r32_a1), .rs2_r_addr(r32_a2), .r_data1(d32), .r_data2(d32),
    .out_valid(ov32), .out_ready(1'b1), .out_pc(opc32), .out_op1(op1_32),
    .out_op2(op2_32), .out_jmp(jmp32), .out_alu(alu32), .out_bj(bj32),
    .out_load(ld32), .out_save(sv32), .out_rd_wena(wena32),
    .out_rd_addr(rd32), .out_mem_rd(mrd32), .out_mem_wr(mwr32),
    .out_is_word(word32), .out_illegal(ill32));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2);
    in_inst = inst; in_pc = pc; r_data1 = r1; r_data2 = r2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== 64'h0 || out_alu !== 10'h0) begin n_fail++; $display("FAIL reset_regs: pc %h alu %h want 0", out_pc, out_alu); end
  endtask

  task automatic test_addi();
    in_inst = 32'hFFF08293; #1;
    n_cmp++; if (rs1_r_ena !== 1'b1 || rs1_r_addr !== 5'd1 || rs2_r_ena !== 1'b0 || rs2_r_addr !== 5'd0) begin
      n_fail++; $display("FAIL addi_rf: e1 %b a1 %0d e2 %b a2 %0d want 1 1 0 0", rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr); end
    issue(32'hFFF08293, 64'h1000, 64'd10, 64'd77);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_op1 !== 64'd10) begin n_fail++; $display("FAIL addi_op1: got %h want a", out_op1); end
    n_cmp++; if (out_op2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL addi_op2: got %h want ffffffffffffffff", out_op2); end
    n_cmp++; if (out_alu !== A_ADD || out_rd_addr !== 5'd5 || out_rd_wena !== 1'b1) begin
      n_fail++; $display("FAIL addi_ctl: alu %h rd %0d we %b want 001 5 1", out_alu, out_rd_addr, out_rd_wena); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_alu_ops();
    issue(32'h402081B3, 64'h2000, 64'd7, 64'd3);
    n_cmp++; if (out_alu !== A_SUB || out_op1 !== 64'd7 || out_op2 !== 64'd3) begin
      n_fail++; $display("FAIL sub: alu %h op1 %h op2 %h want 002 7 3", out_alu, out_op1, out_op2); end
    tick();
    issue(32'h800003B7, 64'h2004, 64'd55, 64'd0);
    n_cmp++; if (out_op1 !== 64'h0 || out_op2 !== 64'hFFFF_FFFF_8000_0000 || out_rd_addr !== 5'd7) begin
      n_fail++; $display("FAIL lui: op1 %h op2 %h rd %0d want 0 ffffffff80000000 7", out_op1, out_op2, out_rd_addr); end
    tick();
    issue(32'h00001097, 64'h3000, 64'd9, 64'd0);
    n_cmp++; if (out_op1 !== 64'h3000 || out_op2 !== 64'h1000) begin
      n_fail++; $display("FAIL auipc: op1 %h op2 %h want 3000 1000", out_op1, out_op2); end
    tick();
    issue(32'hFE20AE23, 64'h3004, 64'h100, 64'h5);
    n_cmp++; if (out_op2 !== 64'hFFFF_FFFF_FFFF_FFFC || out_save !== 4'b0100 || out_mem_wr !== 1'b1 || out_rd_wena !== 1'b0) begin
      n_fail++; $display("FAIL sw: op2 %h save %b wr %b we %b want fffffffffffffffc 0100 1 0", out_op2, out_save, out_mem_wr, out_rd_wena); end
    tick();
    issue(32'hFE208CE3, 64'h3008, 64'd1, 64'd2);
    n_cmp++; if (out_jmp !== 64'hFFFF_FFFF_FFFF_FFF8 || out_bj !== 8'h01 || out_op2 !== 64'd2 || out_rd_wena !== 1'b0) begin
      n_fail++; $display("FAIL beq: jmp %h bj %h op2 %h we %b want fffffffffffffff8 01 2 0", out_jmp, out_bj, out_op2, out_rd_wena); end
    tick();
    issue(32'h0010809B, 64'h300C, 64'd4, 64'd0);
    n_cmp++; if (out_is_word !== 1'b1 || out_rd_wena !== 1'b1 || out_alu !== A_ADD || out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL addiw64: word %b we %b alu %h ill %b want 1 1 001 0", out_is_word, out_rd_wena, out_alu, out_illegal); end
    tick();
  endtask

  task automatic test_jalr();
    issue(32'h003100E7, 64'h4000, 64'h8000_0000, 64'd0);
    n_cmp++; if (out_jmp !== 64'h8000_0002) begin n_fail++; $display("FAIL jalr_jmp: got %h want 80000002", out_jmp); end
    n_cmp++; if (out_bj !== 8'h80 || out_rd_addr !== 5'd1) begin n_fail++; $display("FAIL jalr_ctl: bj %h rd %0d want 80 1", out_bj, out_rd_addr); end
    tick();
  endtask

  task automatic test_illegal();
    issue(32'h0000007F, 64'h5000, 64'd1, 64'd1);
    n_cmp++; if (out_valid !== 1'b1 || out_illegal !== ILL_EXP) begin n_fail++; $display("FAIL ill64_flag: v %b ill %b want 1 %b", out_valid, out_illegal, ILL_EXP); end
    n_cmp++; if (out_rd_wena !== 1'b0 || out_alu !== 10'h0 || out_bj !== 8'h0 || out_mem_rd !== 1'b0 || out_mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL ill64_ena: we %b alu %h bj %h rd %b wr %b want all 0", out_rd_wena, out_alu, out_bj, out_mem_rd, out_mem_wr); end
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    issue(32'h002081B3, 64'h100, 64'd1, 64'd2);
    in_inst = 32'h402081B3; in_pc = 64'h104; in_valid = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready %b want 0", in_ready); end
    in_inst = 32'hFFF08293; in_pc = 64'h108;
    tick();
    n_cmp++; if (out_pc !== 64'h100 || out_valid !== 1'b1 || out_alu !== A_ADD) begin
      n_fail++; $display("FAIL bp_hold: pc %h v %b alu %h want 100 1 001", out_pc, out_valid, out_alu); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_pc !== 64'h104 || out_alu !== A_SUB || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: pc %h alu %h rdy %b want 104 002 1", out_pc, out_alu, in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_pc !== 64'h108 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third: pc %h v %b want 108 1", out_pc, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: v %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_inst = 32'hFFF08293; in_pc = 64'h200 + 64'(4 * i); in_valid = 1'b1;
      tick();
      n_cmp++; if (out_pc !== 64'h200 + 64'(4 * i) || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_%0d: pc %h v %b rdy %b want %h 1 1", i, out_pc, out_valid, in_ready, 64'h200 + 64'(4 * i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    issue(32'h002081B3, 64'h600, 64'd1, 64'd2);
    issue(32'h002081B3, 64'h604, 64'd1, 64'd2);
    in_inst = 32'hFFF08293; in_pc = 64'h608; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush: v %b rdy %b want 0 1", out_valid, in_ready); end
    out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost: v %b pc %h want 0", out_valid, out_pc); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    issue(32'h002081B3, 64'h700, 64'd1, 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 64'h0) begin
      n_fail++; $display("FAIL mid_reset: v %b rdy %b pc %h want 0 1 0", out_valid, in_ready, out_pc); end
    out_ready = 1'b1;
  endtask

  task automatic test_xlen32();
    inst32 = 32'h0010809B; pc32 = 32'h80; d32 = 32'd4; v32 = 1'b1;
    tick();
    v32 = 1'b0;
    n_cmp++; if (ov32 !== 1'b1 || ill32 !== ILL_EXP) begin n_fail++; $display("FAIL x32_addiw_flag: v %b ill %b want 1 %b", ov32, ill32, ILL_EXP); end
    n_cmp++; if (wena32 !== 1'b0 || alu32 !== 10'h0 || word32 !== 1'b0 || bj32 !== 8'h0) begin
      n_fail++; $display("FAIL x32_addiw_nop: we %b alu %h word %b bj %h want 0 0 0 0", wena32, alu32, word32, bj32); end
    inst32 = 32'hFFF08293; d32 = 32'd10; v32 = 1'b1;
    tick();
    v32 = 1'b0;
    n_cmp++; if (op2_32 !== 32'hFFFF_FFFF || op1_32 !== 32'd10 || ill32 !== 1'b0 || alu32 !== A_ADD) begin
      n_fail++; $display("FAIL x32_addi: op1 %h op2 %h ill %b alu %h want a ffffffff 0 001", op1_32, op2_32, ill32, alu32); end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu_ops();
    test_jalr();
    test_illegal();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    test_xlen32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Registered, parametrised instruction-decode stage for the RV64I/RV32I in-order core. It sits between fetch (IF) and execute (EXE). Each cycle it decodes one fetched instruction, reads operands from the register file, and latches the decoded bundle into a 2-entry skid buffer with valid/ready handshakes on both sides, so IF and EXE can stall independently.

## Interface
- `XLEN`, default 64: datapath width, 32 or 64. Word ops (opcodes 0x1b, 0x3b) exist only when `XLEN`=64.
- `ALU_W`, default 10: width of the one-hot ALU select.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: discard all buffered and incoming instructions.
- `in_valid` input 1: IF holds a valid instruction.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `in_inst` input 32: instruction word.
- `in_pc` input XLEN: instruction address.
- `rs1_r_ena`, `rs2_r_ena` output 1 each: register-file read enables. Combinational from `in_inst`.
- `rs1_r_addr`, `rs2_r_addr` output 5 each: read addresses. Forced to 0 when the matching enable is 0.
- `r_data1`, `r_data2` input XLEN: register-file read data, same cycle.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: EXE consumes the bundle.
- `out_pc` output XLEN: PC of the bundle.
- `out_op1`, `out_op2` output XLEN: ALU operands.
- `out_jmp` output XLEN: branch/JAL offset, or absolute JALR target.
- `out_alu` output ALU_W: one-hot ALU operation (ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA).
- `out_bj` output 8: branch/jump type.
- `out_load` output 7: load type.
- `out_save` output 4: store type.
- `out_rd_wena` output 1: destination-register write enable.
- `out_rd_addr` output 5: destination-register address.
- `out_mem_rd`, `out_mem_wr` output 1 each: memory read / memory write.
- `out_is_word` output 1: 32-bit word operation.
- `out_illegal` output 1: undecodable instruction.

## Operation
- **Decode fields:** opcode, func3, func7 and the I/S/B/U/J immediates. Every immediate is sign-extended to XLEN.
- **S-type immediate:** the S-type immediate is {inst[31:25], inst[11:7]}.
- **Operand selection:**
  - op1 = `in_pc` for AUIPC, 0 for LUI, otherwise `r_data1`.
  - op2 = `r_data2` for R-type and branches, otherwise the immediate.
- **Jump target:**
  - JALR: `out_jmp` = (`r_data1` + immI) with bit 0 cleared.
  - Branches and JAL: `out_jmp` = the sign-extended offset.
- **Word ops:** `out_is_word` is set only when `XLEN`=64 and the opcode is 0x1b or 0x3b.
- **Buffer FSM:** states EMPTY, ONE, TWO. Entry M (main) drives the outputs; entry S (skid) holds the overflow.
  - `in_ready` = (state != TWO). It is a registered signal.
  - `push` = `in_valid` & `in_ready`.
  - `pop` = `out_valid` & `out_ready`.
  - EMPTY: push -> ONE (write M).
  - ONE: push & !pop -> TWO (write S). push & pop -> ONE (write M). pop only -> EMPTY.
  - TWO: pop -> ONE (S moves to M). No push is possible in TWO.
- **Flush:** `flush` overrides push and pop. Next state is EMPTY and the word presented that cycle is discarded.
- **Reset:** state EMPTY. `in_ready`=1, `out_valid`=0. Every registered output is 0.

## Timing
- Capture latency is 1 cycle: a bundle pushed at edge N appears on the outputs after edge N, with `out_valid`=1.
- `r_data1`/`r_data2` are sampled at the push edge only. No forwarding occurs inside this block.
- Full throughput is one instruction per cycle while `out_ready`=1.
- `in_ready` falls in the cycle after the buffer becomes TWO. The skid entry absorbs the one in-flight beat.
- Output data is stable while `out_valid`=1 and `out_ready`=0.
- `rst` asserted mid-stream drops all entries at the next edge, with the same result as reset.

## Configuration
- `ID_ILLEGAL_EN`:
  - **Defined:** any opcode/func3/func7 combination not in RV64I (RV32I when `XLEN`=32) sets `out_illegal`=1. That bundle has every enable output forced to 0: `out_rd_wena`, `out_mem_rd`, `out_mem_wr`, `out_alu`, `out_bj`.
  - **Undefined:** `out_illegal` is tied to 0 and unknown encodings pass through as NOPs with all enables 0.

## Test plan
- **Reset then ADDI:** apply reset, then push `addi x5,x1,-1` with `r_data1`=10 -> one cycle later `out_valid`=1, `out_op1`=10, `out_op2`=0xFFFF_FFFF_FFFF_FFFF, ADD one-hot, `out_rd_addr`=5.
- **Back-pressure:** hold `out_ready`=0 and push 3 instructions back to back -> the first two are buffered and `in_ready`=0 after the 2nd. Release `out_ready` -> the bundles drain in order with no loss or duplication.
- **Flush with both entries full:** assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0 and `in_ready`=1, and the in-flight word never appears.
- **JALR target:** `jalr x1,3(x2)` with `r_data1`=0x8000_0000 -> `out_jmp`=0x8000_0002 and JALR bit set in `out_bj`.
- **XLEN=32:** `addiw` with `ID_ILLEGAL_EN` defined -> `out_illegal`=1 and `out_rd_wena`=0. With the macro undefined -> `out_illegal`=0 and the bundle decodes as a NOP.
